// File: rtl/fetch_queue.sv
// Instruction-fetch front end: generates fetch PCs, tracks one outstanding 1-cycle
// memory read, and buffers returned instructions with their PCs for decode.
module fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                       clk,
    input  logic                       rst,
    output logic                       imem_req,
    output logic [31:0]                imem_addr,
    input  logic                       imem_valid,
    input  logic [31:0]                imem_rdata,
    input  logic                       hazardDetected,
    input  logic                       PCSrcD,
    input  logic [31:0]                PCbranchD,
    output logic [31:0]                instructionD,
    output logic [31:0]                PCReg,
    output logic                       validD,
    output logic [$clog2(DEPTH+1)-1:0] fill_level
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    logic [31:0]   fetch_pc_reg, fetch_pc_next;
    logic          inflight_reg, inflight_next;
    logic [31:0]   inflight_pc_reg, inflight_pc_next;
    logic [PW-1:0] wr_ptr_reg, wr_ptr_next;
    logic [PW-1:0] rd_ptr_reg, rd_ptr_next;
    logic [CW-1:0] count_reg, count_next;

    logic [31:0] instr_mem [DEPTH];
    logic [31:0] pc_mem    [DEPTH];

    logic [CW:0] credits_used;
    logic        issue;
    logic        push;
    logic        pop;

    // An outstanding request reserves a slot, so the FIFO can never overflow.
    assign credits_used = {1'b0, count_reg} + {{CW{1'b0}}, inflight_reg};
    assign issue        = !rst && !PCSrcD && (credits_used < (CW+1)'(DEPTH));
    assign push         = imem_valid && inflight_reg && !PCSrcD;
    assign pop          = validD && !hazardDetected && !PCSrcD;

    assign validD       = (count_reg != '0);
    assign instructionD = validD ? instr_mem[rd_ptr_reg] : 32'h0000_0000;
    assign PCReg        = validD ? pc_mem[rd_ptr_reg]    : 32'h0000_0000;
    assign fill_level   = count_reg;
    assign imem_req     = issue;
    assign imem_addr    = fetch_pc_reg;

    always_comb begin
        fetch_pc_next    = fetch_pc_reg;
        inflight_next    = 1'b0;
        inflight_pc_next = inflight_pc_reg;
        wr_ptr_next      = wr_ptr_reg;
        rd_ptr_next      = rd_ptr_reg;
        count_next       = count_reg;

        if (PCSrcD) begin
            // Redirect flushes everything and kills the outstanding response.
            fetch_pc_next = PCbranchD;
            wr_ptr_next   = '0;
            rd_ptr_next   = '0;
            count_next    = '0;
        end else begin
            if (issue) begin
                inflight_next    = 1'b1;
                inflight_pc_next = fetch_pc_reg;
                fetch_pc_next    = fetch_pc_reg + 32'd4;
            end
            if (push) begin
                wr_ptr_next = wr_ptr_reg + PW'(1);
            end
            if (pop) begin
                rd_ptr_next = rd_ptr_reg + PW'(1);
            end
            case ({push, pop})
                2'b10:   count_next = count_reg + CW'(1);
                2'b01:   count_next = count_reg - CW'(1);
                default: count_next = count_reg;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_reg    <= RESET_PC;
            inflight_reg    <= 1'b0;
            inflight_pc_reg <= RESET_PC;
            wr_ptr_reg      <= '0;
            rd_ptr_reg      <= '0;
            count_reg       <= '0;
        end else begin
            fetch_pc_reg    <= fetch_pc_next;
            inflight_reg    <= inflight_next;
            inflight_pc_reg <= inflight_pc_next;
            wr_ptr_reg      <= wr_ptr_next;
            rd_ptr_reg      <= rd_ptr_next;
            count_reg       <= count_next;
        end
    end

    // Payload storage needs no reset; occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            instr_mem[wr_ptr_reg] <= imem_rdata;
            pc_mem[wr_ptr_reg]    <= inflight_pc_reg;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: a 1-cycle memory model answers requests and a PC
// scoreboard predicts what decode sees each cycle.
module tb_fetch_queue;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_valid;
    logic [31:0] imem_rdata;
    logic        hazardDetected;
    logic        PCSrcD;
    logic [31:0] PCbranchD;
    logic [31:0] instructionD;
    logic [31:0] PCReg;
    logic        validD;
    logic [2:0]  fill_level;

    int checks   = 0;
    int failures = 0;

    logic [31:0] q_pc[$];
    logic [31:0] m_pc;
    logic [31:0] m_inflight_pc;
    logic        m_inflight;
    bit          model_live   = 1'b0;
    logic        cap_req;
    logic [31:0] cap_addr;
    logic        inject_valid = 1'b0;

    fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_valid     (imem_valid),
        .imem_rdata     (imem_rdata),
        .hazardDetected (hazardDetected),
        .PCSrcD         (PCSrcD),
        .PCbranchD      (PCbranchD),
        .instructionD   (instructionD),
        .PCReg          (PCReg),
        .validD         (validD),
        .fill_level     (fill_level)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'h2000_0000 + (a >> 2);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic model_req();
        return !rst && !PCSrcD && ((q_pc.size() + int'(m_inflight)) < DEPTH);
    endfunction

    task automatic model_compare();
        logic [31:0] head;
        head = (q_pc.size() != 0) ? q_pc[0] : 32'h0;
        chk("imem_req",     {31'b0, imem_req},  {31'b0, model_req()});
        chk("imem_addr",    imem_addr,          m_pc);
        chk("validD",       {31'b0, validD},    {31'b0, q_pc.size() != 0});
        chk("PCReg",        PCReg,              head);
        chk("instructionD", instructionD,       (q_pc.size() != 0) ? mem_word(head) : 32'h0);
        chk("fill_level",   {29'b0, fill_level}, 32'(q_pc.size()));
    endtask

    task automatic model_advance();
        logic req, push, pop;
        req  = model_req();
        push = imem_valid && m_inflight && !PCSrcD;
        pop  = (q_pc.size() != 0) && !hazardDetected && !PCSrcD;
        if (rst) begin
            q_pc.delete();
            m_pc       = RESET_PC;
            m_inflight = 1'b0;
            model_live = 1'b1;
        end else if (PCSrcD) begin
            q_pc.delete();
            m_pc       = PCbranchD;
            m_inflight = 1'b0;
        end else begin
            if (push && !pop)
                chk("no_overflow", {31'b0, fill_level < 3'd4}, 32'd1);
            if (pop)  void'(q_pc.pop_front());
            if (push) q_pc.push_back(m_inflight_pc);
            if (req) begin
                m_inflight_pc = m_pc;
                m_inflight    = 1'b1;
                m_pc          = m_pc + 32'd4;
            end else begin
                m_inflight = 1'b0;
            end
        end
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic finish_cycle();
        if (model_live) model_compare();
        model_advance();
        cap_req  = imem_req;
        cap_addr = imem_addr;
        @(posedge clk);
        #1;
        imem_valid   = cap_req | inject_valid;
        imem_rdata   = cap_req ? mem_word(cap_addr) : 32'hDEAD_BEEF;
        inject_valid = 1'b0;
    endtask

    task automatic cyc();
        settle();
        finish_cycle();
    endtask

    // Builds 3 queued entries plus one in flight, then redirects to target.
    task automatic redirect_case(input string name, input logic [31:0] target, input logic haz);
        int n;
        hazardDetected = 1'b1;
        n = 0;
        while (!(q_pc.size() == 3 && m_inflight) && n < 20) begin
            cyc();
            n++;
        end
        if (n >= 20) begin
            checks++;
            failures++;
            $display("FAIL %s_setup observed=no_3_entries expected=3_entries", name);
        end
        PCSrcD = 1'b1; PCbranchD = target; hazardDetected = haz;
        settle();
        chk({name, "_fill_before"}, {29'b0, fill_level}, 32'd3);
        chk({name, "_req_R"},       {31'b0, imem_req},   32'd0);
        finish_cycle();
        PCSrcD = 1'b0; hazardDetected = 1'b0;
        settle();
        chk({name, "_valid_R1"}, {31'b0, validD},    32'd0);
        chk({name, "_fill_R1"},  {29'b0, fill_level}, 32'd0);
        chk({name, "_req_R1"},   {31'b0, imem_req},  32'd1);
        chk({name, "_addr_R1"},  imem_addr,          target);
        finish_cycle();
        settle();
        chk({name, "_valid_R2"}, {31'b0, validD},    32'd0);
        chk({name, "_addr_R2"},  imem_addr,          target + 32'd4);
        finish_cycle();
        settle();
        chk({name, "_valid_R3"}, {31'b0, validD},    32'd1);
        chk({name, "_pc_R3"},    PCReg,              target);
        chk({name, "_instr_R3"}, instructionD,       mem_word(target));
        finish_cycle();
        $display("redirect %s target=%h done", name, target);
    endtask

    initial begin
        rst = 1'b1; hazardDetected = 1'b0; PCSrcD = 1'b0; PCbranchD = 32'h0;
        imem_valid = 1'b0; imem_rdata = 32'h0;
        #1;
        cyc();
        settle();
        chk("rst_req",   {31'b0, imem_req},   32'd0);
        chk("rst_addr",  imem_addr,           RESET_PC);
        chk("rst_valid", {31'b0, validD},     32'd0);
        chk("rst_instr", instructionD,        32'd0);
        chk("rst_pc",    PCReg,               32'd0);
        chk("rst_fill",  {29'b0, fill_level}, 32'd0);
        finish_cycle();

        // Streaming after reset release
        rst = 1'b0;
        settle();
        chk("c0_req",  {31'b0, imem_req}, 32'd1);
        chk("c0_addr", imem_addr,         32'd0);
        finish_cycle();
        settle();
        chk("c1_addr",  imem_addr,        32'd4);
        chk("c1_valid", {31'b0, validD},  32'd0);
        finish_cycle();
        settle();
        chk("c2_valid", {31'b0, validD},     32'd1);
        chk("c2_pc",    PCReg,               32'd0);
        chk("c2_instr", instructionD,        32'h2000_0000);
        chk("c2_fill",  {29'b0, fill_level}, 32'd1);
        chk("c2_addr",  imem_addr,           32'd8);
        finish_cycle();
        $display("stream start done");

        // Stall for 10 cycles: head holds at PC 4 while the queue fills.
        hazardDetected = 1'b1;
        for (int i = 0; i < 10; i++) begin
            settle();
            chk("stall_pc", PCReg, 32'd4);
            if (i >= 3) begin
                chk("stall_fill", {29'b0, fill_level}, 32'd4);
                chk("stall_req",  {31'b0, imem_req},   32'd0);
            end
            finish_cycle();
        end
        hazardDetected = 1'b0;
        for (int i = 0; i < 5; i++) begin
            settle();
            chk("drain_pc",    PCReg,        32'(4 + 4 * i));
            chk("drain_instr", instructionD, mem_word(32'(4 + 4 * i)));
            finish_cycle();
        end
        $display("stall and drain done");

        redirect_case("redir_plain",  32'h0000_0100, 1'b0);
        redirect_case("redir_hazard", 32'h0000_0200, 1'b1);
        redirect_case("redir_unalgn", 32'h0000_0303, 1'b0);
        redirect_case("redir_wrap",   32'hFFFF_FFFC, 1'b0);
        settle();
        chk("wrap_pc",    PCReg,        32'h0000_0000);
        chk("wrap_instr", instructionD, 32'h2000_0000);
        finish_cycle();

        // Mid-stream reset with a stray response the cycle after.
        cyc(); cyc(); cyc();
        rst = 1'b1;
        inject_valid = 1'b1;
        settle();
        chk("mrst_req", {31'b0, imem_req}, 32'd0);
        finish_cycle();
        rst = 1'b0;
        settle();
        chk("mrst_fill0",  {29'b0, fill_level}, 32'd0);
        chk("mrst_valid0", {31'b0, validD},     32'd0);
        chk("mrst_req0",   {31'b0, imem_req},   32'd1);
        chk("mrst_addr0",  imem_addr,           RESET_PC);
        finish_cycle();
        settle();
        chk("mrst_fill1",  {29'b0, fill_level}, 32'd0);
        chk("mrst_valid1", {31'b0, validD},     32'd0);
        chk("mrst_addr1",  imem_addr,           RESET_PC + 32'd4);
        finish_cycle();
        settle();
        chk("mrst_valid2", {31'b0, validD},     32'd1);
        chk("mrst_pc2",    PCReg,               RESET_PC);
        chk("mrst_fill2",  {29'b0, fill_level}, 32'd1);
        finish_cycle();
        $display("mid-stream reset done");
        cyc(); cyc(); cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
